// File: rtl/register_file_pkg.sv
// Shared constants for the MIPS general-purpose register file.
// Register 0 is architecturally hardwired to zero.
package register_file_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;
endpackage : register_file_pkg

// File: rtl/register_file.sv
// Three-port MIPS register file: two combinational read ports, one clocked
// write port, synchronous active-high reset, register 0 always reads zero.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we3,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  input  logic [ADDR_WIDTH-1:0] wa3,
  input  logic [DATA_WIDTH-1:0] wd3,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int                  DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  wr_en_d;

  // Writes to register 0 are dropped so its storage only ever holds reset value.
  assign wr_en_d = we3 && (wa3 != ZERO_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[wa3] <= wd3;
    end
  end

  // The zero guard on reads keeps address 0 at zero even before the first reset.
  assign rd1 = (ra1 == ZERO_ADDR) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == ZERO_ADDR) ? '0 : regs_q[ra2];

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file with hand-computed
// expectations and a few hand-written reset/priority sequences.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          we3;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  int total;
  int bad;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .we3   (we3),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic w, logic [AW-1:0] wa, logic [DW-1:0] wd,
                              logic [AW-1:0] a1, logic [AW-1:0] a2,
                              logic [DW-1:0] e1, logic [DW-1:0] e2);
    vec_t v;
    v.we = w; v.wa = wa; v.wd = wd; v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2);
    reset = rst; we3 = w; wa3 = wa; wd3 = wd; ra1 = a1; ra2 = a2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b0, 1'b0, '0, '0, '0, '0);

    // Vectors are applied after a falling edge and checked before the next
    // rising edge, so each row sees the writes of earlier rows only.
    vecs[0]  = mk(1'b1, 5'd1,  32'hA5A5A5A5, 5'd1,  5'd0,  32'h00000000, 32'h00000000);
    vecs[1]  = mk(1'b1, 5'd2,  32'h5A5A5A5A, 5'd1,  5'd2,  32'hA5A5A5A5, 32'h00000000);
    vecs[2]  = mk(1'b0, 5'd1,  32'h00000000, 5'd1,  5'd2,  32'hA5A5A5A5, 32'h5A5A5A5A);
    vecs[3]  = mk(1'b0, 5'd0,  32'h00000000, 5'd0,  5'd2,  32'h00000000, 32'h5A5A5A5A);
    vecs[4]  = mk(1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd1,  32'h00000000, 32'hA5A5A5A5);
    vecs[5]  = mk(1'b0, 5'd3,  32'h12345678, 5'd0,  5'd3,  32'h00000000, 32'h00000000);
    vecs[6]  = mk(1'b0, 5'd0,  32'h00000000, 5'd3,  5'd3,  32'h00000000, 32'h00000000);
    vecs[7]  = mk(1'b1, 5'd4,  32'hDEADBEEF, 5'd4,  5'd4,  32'h00000000, 32'h00000000);
    vecs[8]  = mk(1'b1, 5'd4,  32'h11111111, 5'd4,  5'd4,  32'hDEADBEEF, 32'hDEADBEEF);
    vecs[9]  = mk(1'b1, 5'd4,  32'h22222222, 5'd4,  5'd1,  32'h11111111, 32'hA5A5A5A5);
    vecs[10] = mk(1'b1, 5'd31, 32'h80000001, 5'd4,  5'd31, 32'h22222222, 32'h00000000);
    vecs[11] = mk(1'b0, 5'd0,  32'h00000000, 5'd31, 5'd30, 32'h80000001, 32'h00000000);

    // Address 0 reads zero even before any reset.
    #1;
    check("pre_reset_r0_rd1", rd1, '0);
    check("pre_reset_r0_rd2", rd2, '0);

    @(negedge clk);
    drive(1'b1, 1'b0, '0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 32; i++) begin
      ra1 = AW'(i);
      ra2 = AW'(31 - i);
      #1;
      check($sformatf("reset_sweep_rd1[%0d]", i), rd1, '0);
      check($sformatf("reset_sweep_rd2[%0d]", 31 - i), rd2, '0);
    end

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].a1, vecs[i].a2);
      #1;
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
    end

    // Reset wins over a simultaneous write and clears earlier contents.
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 5'd5, 5'd1);
    #1;
    check("rst_prio_r5", rd1, '0);
    check("rst_prio_r1", rd2, '0);
    ra1 = 5'd2; ra2 = 5'd31;
    #1;
    check("rst_prio_r2", rd1, '0);
    check("rst_prio_r31", rd2, '0);
    ra1 = 5'd4;
    #1;
    check("rst_prio_r4", rd1, '0);

    // Writes resume on the first edge with reset low.
    drive(1'b0, 1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd5);
    @(posedge clk);
    #1;
    check("post_rst_wr_rd1", rd1, 32'hCAFEF00D);
    check("post_rst_wr_rd2", rd2, 32'hCAFEF00D);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 5'd6, 5'd5);
    #1;
    check("post_rst_neighbour", rd1, '0);
    check("post_rst_hold", rd2, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_register_file
